// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Sequenced FIR engine: an N_TAPS-deep sample history and a writable
//   coefficient bank share one signed multiply-accumulate unit, one tap per
//   clock. A sample is accepted in IDLE, MAC runs for N_TAPS cycles, and OUT
//   writes the saturated sum to y_out with a one-cycle y_valid pulse.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   cfg_we    in   coefficient write strobe (honoured only in IDLE)
//   cfg_addr  in   coefficient index (indices >= N_TAPS are ignored)
//   cfg_data  in   coefficient value, signed
//   in_valid  in   sample offered
//   in_ready  out  block can accept a sample (high in IDLE)
//   x_in      in   sample data, signed
//   y_valid   out  one-cycle pulse when y_out is updated
//   y_out     out  saturated filter result, held between updates
//   busy      out  high in MAC and OUT
module fir_mac_sequencer #(
  parameter int N_TAPS  = 10,
  parameter int BW_IN   = 2,
  parameter int BW_COEF = 4,
  parameter int BW_OUT  = 8,
  localparam int AW     = $clog2(N_TAPS),
  localparam int ACC_W  = BW_IN + BW_COEF + AW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic signed [BW_COEF-1:0] cfg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BW_IN-1:0]   x_in,
  output logic                      y_valid,
  output logic signed [BW_OUT-1:0]  y_out,
  output logic                      busy
);

  localparam int PW = BW_IN + BW_COEF;
  localparam int SW = (ACC_W > BW_OUT) ? ACC_W : BW_OUT;

  localparam logic [AW-1:0] K_LAST   = AW'(N_TAPS - 1);
  localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(N_TAPS);

  // Clamp bounds expressed at the wider of accumulator / output width so the
  // comparison is exact whichever of the two is larger.
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW - BW_OUT + 1){1'b0}}, {(BW_OUT - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW - BW_OUT + 1){1'b1}}, {(BW_OUT - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                     state;
  logic [AW-1:0]              k;
  logic signed [ACC_W-1:0]    acc;
  logic signed [BW_IN-1:0]    x_hist [N_TAPS];
  logic signed [BW_COEF-1:0]  coef   [N_TAPS];

  logic signed [PW-1:0]       x_ext;
  logic signed [PW-1:0]       c_ext;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic                       cfg_hit;

  // Saturate the accumulator into the output range. When the output is at
  // least as wide as the accumulator the bounds can never be crossed and the
  // value simply passes through sign-extended.
  function automatic logic signed [BW_OUT-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [SW-1:0] aw;
    aw = SW'(a);
    if (aw > SAT_MAX)      sat = SAT_MAX[BW_OUT-1:0];
    else if (aw < SAT_MIN) sat = SAT_MIN[BW_OUT-1:0];
    else                   sat = BW_OUT'(aw);
  endfunction

  // Multiply stage: full-precision signed product of the current tap,
  // sign-extended to accumulator width.
  always_comb begin
    x_ext    = PW'(x_hist[k]);
    c_ext    = PW'(coef[k]);
    prod     = x_ext * c_ext;
    prod_ext = ACC_W'(prod);
    cfg_hit  = cfg_we && ({1'b0, cfg_addr} < ADDR_LIM);
  end

  // Control, history, coefficient bank and accumulate stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      acc      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        x_hist[i] <= '0;
        coef[i]   <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A write coincident with acceptance lands before the first MAC
          // cycle, so that sample already sees the new coefficient.
          if (cfg_hit) coef[cfg_addr] <= cfg_data;
          if (in_valid && in_ready) begin
            x_hist[0] <= x_in;
            for (int i = N_TAPS - 1; i > 0; i--) x_hist[i] <= x_hist[i-1];
            acc      <= '0;
            k        <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + AW'(1);
          if (k == K_LAST) state <= OUT;
        end
        OUT: begin
          y_out    <= sat(acc);
          y_valid  <= 1'b1;
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  localparam int N_TAPS  = 10;
  localparam int BW_IN   = 2;
  localparam int BW_COEF = 4;
  localparam int BW_OUT  = 8;
  localparam int AW      = 4;
  localparam int LAT     = N_TAPS + 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      cfg_we;
  logic [AW-1:0]             cfg_addr;
  logic signed [BW_COEF-1:0] cfg_data;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BW_IN-1:0]   x_in;
  logic                      y_valid;
  logic signed [BW_OUT-1:0]  y_out;
  logic                      busy;

  fir_mac_sequencer #(
    .N_TAPS(N_TAPS), .BW_IN(BW_IN), .BW_COEF(BW_COEF), .BW_OUT(BW_OUT)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_valid(y_valid), .y_out(y_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state and scoreboard
  int m_x [N_TAPS];
  int m_c [N_TAPS];
  int exp_q [$];
  int acc_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int model_sat(int s);
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N_TAPS; i++) begin
      m_x[i] = 0;
      m_c[i] = 0;
    end
    exp_q.delete();
    acc_q.delete();
  endfunction

  function automatic void model_accept(int x, int at_cyc);
    int s;
    for (int i = N_TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = x;
    s = 0;
    for (int i = 0; i < N_TAPS; i++) s += m_x[i] * m_c[i];
    exp_q.push_back(model_sat(s));
    acc_q.push_back(at_cyc);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(int addr, int data, bit applies);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr[AW-1:0]; cfg_data = data[BW_COEF-1:0];
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (applies && addr < N_TAPS) m_c[addr] = data;
  endtask

  task automatic send(int x, bit we = 1'b0, int addr = 0, int data = 0);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; x_in = x[BW_IN-1:0];
    cfg_we = we; cfg_addr = addr[AW-1:0]; cfg_data = data[BW_COEF-1:0];
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready got in_ready=%0b want 1", in_ready);
    end
    if (we && addr < N_TAPS) m_c[addr] = data;
    model_accept(x, cyc);
    @(posedge clk);
    #1 in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  // Waits (bounded) for the next y_valid and pairs it with the scoreboard head.
  task automatic get_out(output bit ok, output int y, output int exp, output int lat);
    int n;
    n = 0; ok = 1'b0; y = 0; exp = 0; lat = -1;
    @(negedge clk);
    while (!y_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (y_valid === 1'b1 && exp_q.size() > 0) begin
      ok  = 1'b1;
      y   = int'(y_out);
      exp = exp_q.pop_front();
      lat = cyc - acc_q.pop_front();
    end
  endtask

  task automatic test_reset();
    bit ok; int y, e, lat;
    do_reset();
    @(negedge clk);
    n_checks++; if (y_out !== 8'sd0) begin n_fail++; $display("FAIL reset_y_out got %0d want 0", y_out); end
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid got %0b want 0", y_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    send(1);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mac_busy got %0b want 1", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mac_in_ready got %0b want 0", in_ready); end
    get_out(ok, y, e, lat);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_out_present got none want pulse"); end
    n_checks++; if (y !== e) begin n_fail++; $display("FAIL reset_default_y got %0d want %0d", y, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL reset_latency got %0d want %0d", lat, LAT); end
    @(negedge clk);
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL y_valid_pulse got %0b want 0", y_valid); end
  endtask

  task automatic test_impulse();
    bit ok; int y, e, lat;
    int ct [N_TAPS] = '{1, 2, 3, 4, 5, 6, 7, -1, -2, -3};
    do_reset();
    for (int i = 0; i < N_TAPS; i++) write_coef(i, ct[i], 1'b1);
    for (int i = 0; i <= N_TAPS; i++) begin
      send(i == 0 ? 1 : 0);
      get_out(ok, y, e, lat);
      n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL impulse[%0d] got %0d want %0d", i, y, e); end
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL impulse_lat[%0d] got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_saturation(int cval, string tag);
    bit ok; int y, e, lat;
    do_reset();
    for (int i = 0; i < N_TAPS; i++) write_coef(i, cval, 1'b1);
    for (int i = 0; i < N_TAPS; i++) begin
      send(-2);
      get_out(ok, y, e, lat);
      n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL %s[%0d] got %0d want %0d", tag, i, y, e); end
    end
  endtask

  task automatic test_back_to_back();
    int last, accepts, lows, y, e;
    do_reset();
    write_coef(0, 1, 1'b1);
    write_coef(1, 1, 1'b1);
    write_coef(2, 1, 1'b1);
    last = -1; accepts = 0; lows = 0;
    @(negedge clk);
    in_valid = 1'b1; x_in = 2'sd1;
    for (int i = 0; i < 3 * LAT; i++) begin
      if (i > 0) @(negedge clk);
      if (y_valid === 1'b1) begin
        y = int'(y_out);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -999;
        if (acc_q.size() > 0) void'(acc_q.pop_front());
        n_checks++; if (y !== e) begin n_fail++; $display("FAIL b2b_y got %0d want %0d", y, e); end
      end
      if (in_ready === 1'b1) begin
        if (last >= 0) begin
          n_checks++; if (cyc - last !== LAT) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last, LAT); end
        end
        last = cyc;
        accepts++;
        model_accept(1, cyc);
      end else begin
        lows++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (accepts !== 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", accepts); end
    n_checks++; if (lows !== 3 * (LAT - 1)) begin n_fail++; $display("FAIL b2b_ready_low got %0d want %0d", lows, 3 * (LAT - 1)); end
    begin
      bit ok; int lat;
      get_out(ok, y, e, lat);
      n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL b2b_last got %0d want %0d", y, e); end
    end
  endtask

  task automatic test_config();
    bit ok; int y, e, lat;
    do_reset();
    write_coef(0, 2, 1'b1);
    send(1);
    repeat (2) @(negedge clk);
    write_coef(0, 5, 1'b0);          // lands in MAC: must be dropped
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL cfg_first got %0d want %0d", y, e); end
    send(1);
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL cfg_mac_write_dropped got %0d want %0d", y, e); end
    write_coef(0, 5, 1'b1);
    send(1);
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL cfg_idle_write got %0d want %0d", y, e); end
    write_coef(12, 7, 1'b1);         // out-of-range index: model ignores it
    for (int i = 0; i < 2; i++) begin
      send(1);
      get_out(ok, y, e, lat);
      n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL cfg_addr_oob[%0d] got %0d want %0d", i, y, e); end
    end
    send(0, 1'b1, 1, 3);             // write coincident with acceptance
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL cfg_coincident got %0d want %0d", y, e); end
  endtask

  task automatic test_reset_mid();
    bit ok; int y, e, lat, pulses;
    do_reset();
    write_coef(0, 3, 1'b1);
    send(1);
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL mid_pre got %0d want %0d", y, e); end
    send(1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (y_valid === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_no_pulse got %0d want 0", pulses); end
    n_checks++; if (y_out !== 8'sd0) begin n_fail++; $display("FAIL mid_y_out got %0d want 0", y_out); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl got ready=%0b busy=%0b want 1 0", in_ready, busy); end
    send(1);
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL mid_coef_cleared got %0d want %0d", y, e); end
    write_coef(1, 3, 1'b1);
    write_coef(2, 3, 1'b1);
    send(0);
    get_out(ok, y, e, lat);
    n_checks++; if (!ok || y !== e) begin n_fail++; $display("FAIL mid_hist_cleared got %0d want %0d", y, e); end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; x_in = '0;
    test_reset();
    test_impulse();
    test_saturation(-8, "pos_sat");
    test_saturation(7, "neg_sat");
    test_back_to_back();
    test_config();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
